datamem_arbiter: RTL and testbench
==================================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 The block SHALL have parameter addresswidth, default 32, which is the address width of both requester ports and the memory port.
REQ-002 The block SHALL have parameter width, default 32, which is the data width of both requester ports and the memory port.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (loader).
- we0, we1  input  1 each  1 = write, 0 = read; held stable while req is high.
- addr0, addr1  input  addresswidth each  access address.
- wdata0, wdata1  input  width each  write data.
- gnt0, gnt1  output  1 each  grant; high for the ACCESS cycle of the winning port.
- ack0, ack1  output  1 each  one-cycle completion pulse to the port that owns the access.
- rdata0, rdata1  output  width each  read data; valid when ack is high and the access was a read.
- mem_address  output  addresswidth  address to the data memory.
- mem_write_en  output  1  write enable to the data memory.
- mem_read_en  output  1  read enable to the data memory.
- mem_data_in  output  width  write data to the data memory.
- mem_data_out  input  width  read data from the data memory; registered by the memory on negedge clk.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP, and SHALL be updated on posedge clk.
REQ-005 In IDLE or RESP, if req0 or req1 is high, the FSM SHALL move to ACCESS; otherwise it SHALL move to IDLE.
REQ-006 On that same edge, the block SHALL latch the winner's id, we, addr and wdata.
REQ-007 ACCESS SHALL always last exactly one cycle and SHALL always be followed by RESP.
REQ-008 The block SHALL ignore req0 and req1 while in ACCESS.
REQ-009 Arbitration SHALL work as follows:
- If exactly one port requests, that port wins.
- If both ports request, the port not granted most recently wins (round-robin).
- A last_grant register SHALL record the most recent winner; its reset value is 1, so port 0 wins the first tie.
REQ-010 gntN SHALL be a registered output that is high only during the ACCESS cycle of port N; at most one gnt SHALL be high at any time.
REQ-011 During ACCESS, the memory outputs SHALL be driven from the latched request:
- mem_address = latched addr
- mem_data_in = latched wdata
- mem_write_en = latched we
- mem_read_en = !latched we
REQ-012 Outside ACCESS, and in any cycle where reset is high, the block SHALL drive mem_write_en and mem_read_en to 0 and mem_address and mem_data_in to 0.
REQ-013 On the posedge ending ACCESS, for a read, the block SHALL capture mem_data_out into rdataN of the owner.
REQ-014 On that same edge, the block SHALL set ackN high for exactly the RESP cycle of the owner.
REQ-015 For a write, ackN SHALL pulse high in RESP and rdataN SHALL remain unchanged.
REQ-016 rdataN SHALL hold its value until the next read completes on port N.
REQ-017 Requester protocol:
- Keep req, we, addr and wdata stable until gnt is seen.
- Deassert req on the edge ending ACCESS unless it wants another access.
- A req still high in RESP SHALL be arbitrated as a new request.
REQ-018 Latency from a req sampled at edge E SHALL be: gnt high in cycle E..E+1, ack high in cycle E+1..E+2.
REQ-019 Peak throughput SHALL be one access every two cycles (alternating ACCESS and RESP).
REQ-020 The response to a request accepted from RESP SHALL be scheduled so that ack for the prior access and gnt for the new access can never collide on the same port.
REQ-021 All access addresses SHALL be passed through unmodified; address range checking is the responsibility of the memory.

Reset
REQ-022 While reset is high at posedge clk, the block SHALL:
- move the FSM to IDLE,
- set gnt0, gnt1, ack0 and ack1 to 0,
- set rdata0 and rdata1 to 0,
- set last_grant to 1,
- clear the latched request to all zeros.
REQ-023 A reset asserted during ACCESS SHALL abort the access with no ack, and SHALL suppress mem_write_en combinationally in that cycle so that no memory write occurs.
REQ-024 A reset asserted during RESP SHALL clear ack on the next edge; the aborted response is lost.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single write, then read: port 0 writes 0xDEADBEEF to 0x10, then reads 0x10. Required: mem_write_en is high for one cycle with mem_address 0x10; on the read, ack0 pulses and rdata0 = 0xDEADBEEF two cycles after the req edge.
- Simultaneous requests after reset: req0 and req1 are both high. Required: gnt0 first, then gnt1 in the next ACCESS; ack0 and ack1 occur 2 cycles apart.
- Sustained contention: both ports hold req for 8 accesses. Required: grants alternate 0,1,0,1...; no port is granted twice in a row; one ack every 2 cycles.
- Back-to-back single port: port 1 holds req with addr 0x0..0x3 for reads. Required: 4 gnt1 pulses 2 cycles apart, and rdata1 matches preloaded memory contents.
- Reset mid-write: reset is asserted in the ACCESS cycle of a write of 0x12345678 to 0x20. Required: mem_write_en = 0 in that cycle, a later read of 0x20 returns the old value, and no ack is produced.
- Idle: no requests for 10 cycles. Required: mem_read_en = mem_write_en = 0 throughout and all gnt and ack outputs are 0.

Source files
------------

// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Two-port round-robin arbiter in front of a single data memory. Port 0 is
//   the CPU and port 1 is the loader. Each access takes an ACCESS cycle, in
//   which the memory is driven, followed by a RESP cycle, in which the owner
//   sees its ack (and read data for a read).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
//   them until gntN is seen. gntN is high for the ACCESS cycle. ackN is high
//   for the following RESP cycle. A req still high in RESP counts as a new
//   request.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   req0/1, we0/1              request and write (1) / read (0) per port
//   addr0/1, wdata0/1          access address and write data per port
//   gnt0/1, ack0/1             registered grant and completion pulses
//   rdata0/1                   last read data per port
//   mem_address, mem_write_en,
//   mem_read_en, mem_data_in   memory command, live only in ACCESS
//   mem_data_out               memory read data (memory registers on negedge)
//   dbg_state                  FSM state for observation (0 IDLE, 1 ACCESS, 2 RESP)
module datamem_arbiter #(
  parameter int addresswidth = 32,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [addresswidth-1:0] addr0,
  input  logic [addresswidth-1:0] addr1,
  input  logic [width-1:0]        wdata0,
  input  logic [width-1:0]        wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [width-1:0]        rdata0,
  output logic [width-1:0]        rdata1,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [width-1:0]        mem_data_in,
  input  logic [width-1:0]        mem_data_out,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    gnt0_q, gnt1_q;
  logic                    ack0_q, ack1_q;
  logic [width-1:0]        rdata0_q, rdata1_q;
  logic                    last_grant_q;
  logic                    lat_id_q;
  logic                    lat_we_q;
  logic [addresswidth-1:0] lat_addr_q;
  logic [width-1:0]        lat_wdata_q;

  logic any_req;
  logic win_id_d;
  logic in_access;

  // On a tie the port that did not win last time goes next; otherwise the
  // single requester wins.
  always_comb begin
    any_req  = req0 | req1;
    win_id_d = 1'b0;
    if (req0 && req1) win_id_d = ~last_grant_q;
    else              win_id_d = req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= 1'b1;
      lat_id_q     <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (any_req) begin
            state_q      <= ST_ACCESS;
            last_grant_q <= win_id_d;
            lat_id_q     <= win_id_d;
            lat_we_q     <= win_id_d ? we1    : we0;
            lat_addr_q   <= win_id_d ? addr1  : addr0;
            lat_wdata_q  <= win_id_d ? wdata1 : wdata0;
            gnt0_q       <= ~win_id_d;
            gnt1_q       <= win_id_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Requests are ignored here; the access always completes into RESP.
          state_q <= ST_RESP;
          if (lat_id_q) begin
            ack1_q <= 1'b1;
            if (!lat_we_q) rdata1_q <= mem_data_out;
          end else begin
            ack0_q <= 1'b1;
            if (!lat_we_q) rdata0_q <= mem_data_out;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the memory command combinationally so an access interrupted
  // by reset never writes.
  assign in_access    = (state_q == ST_ACCESS) && !reset;
  assign mem_address  = in_access ? lat_addr_q  : '0;
  assign mem_data_in  = in_access ? lat_wdata_q : '0;
  assign mem_write_en = in_access &  lat_we_q;
  assign mem_read_en  = in_access & ~lat_we_q;

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic          mem_write_en, mem_read_en;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic [1:0]    dbg_state;

  datamem_arbiter #(.addresswidth(AW), .width(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // Data memory model: registers on negedge, preloaded with A000_0000 + index.
  logic [DW-1:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
  always @(negedge clk) begin
    if (mem_write_en) mem[mem_address[5:0]] <= mem_data_in;
    mem_data_out <= mem[mem_address[5:0]];
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set_req1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_gnt_ack", {gnt0, gnt1, ack0, ack1}, 4'b0000);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_mem_cmd", {mem_read_en, mem_write_en}, 2'b00);

    // Single write then read on port 0
    set_req0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("wr_gnt", {gnt0, gnt1}, 2'b10);
    chk("wr_state", dbg_state, 2'd1);
    chk("wr_we_re", {mem_write_en, mem_read_en}, 2'b10);
    chk("wr_addr", mem_address, 32'h10);
    chk("wr_data", mem_data_in, 32'hDEADBEEF);
    req0 = 1'b0;
    tick();
    chk("wr_ack", {ack0, ack1, gnt0}, 3'b100);
    chk("wr_we_off", mem_write_en, 1'b0);
    chk("wr_rdata_hold", rdata0, 32'h0);
    set_req0(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("rd_gnt", gnt0, 1'b1);
    chk("rd_re", {mem_read_en, mem_write_en}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("rd_ack", ack0, 1'b1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    tick();
    chk("rd_idle", {dbg_state, ack0}, 3'b000);
    chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

    // Simultaneous requests after reset: port 0 wins first tie
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req0(1'b1, 1'b0, 32'h7, 32'h0);
    set_req1(1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    chk("sim_gnt_a", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("sim_ack_a", {ack0, ack1}, 2'b10);
    chk("sim_rdata0", rdata0, 32'hA000_0007);
    tick();
    chk("sim_gnt_b", {gnt0, gnt1, ack0, ack1}, 4'b0100);
    req1 = 1'b0;
    tick();
    chk("sim_ack_b", {ack0, ack1}, 2'b01);
    chk("sim_rdata1", rdata1, 32'hA000_0008);
    tick();

    // Sustained contention: 8 accesses alternate 0,1,0,1...
    set_req0(1'b1, 1'b0, 32'h4, 32'h0);
    set_req1(1'b1, 1'b0, 32'h5, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("cont_gnt_%0d", i), {gnt0, gnt1, ack0, ack1},
          (i % 2 == 0) ? 4'b1000 : 4'b0100);
      if (i == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
      chk($sformatf("cont_ack_%0d", i), {gnt0, gnt1, ack0, ack1},
          (i % 2 == 0) ? 4'b0010 : 4'b0001);
    end
    chk("cont_rdata0", rdata0, 32'hA000_0004);
    chk("cont_rdata1", rdata1, 32'hA000_0005);
    tick();

    // Back-to-back reads on port 1, addresses 0..3
    for (int i = 0; i < 4; i++) begin
      set_req1(1'b1, 1'b0, AW'(i), 32'h0);
      tick();
      chk($sformatf("b2b_gnt_%0d", i), {gnt0, gnt1}, 2'b01);
      chk($sformatf("b2b_addr_%0d", i), mem_address, 64'(i));
      if (i == 3) req1 = 1'b0;
      tick();
      chk($sformatf("b2b_ack_%0d", i), {gnt1, ack1}, 2'b01);
      chk($sformatf("b2b_rdata_%0d", i), rdata1, 32'hA000_0000 + 32'(i));
    end
    tick();

    // Reset asserted in the ACCESS cycle of a write
    set_req0(1'b1, 1'b1, 32'h20, 32'h12345678);
    tick();
    chk("rmw_gnt", gnt0, 1'b1);
    reset = 1'b1;
    #1;
    chk("rmw_we_gated", {mem_write_en, mem_read_en}, 2'b00);
    chk("rmw_addr_zero", mem_address, 32'h0);
    req0 = 1'b0;
    tick();
    chk("rmw_no_ack", {ack0, ack1, gnt0, gnt1}, 4'b0000);
    chk("rmw_state", dbg_state, 2'd0);
    reset = 1'b0;
    tick();
    chk("rmw_no_ack2", {ack0, ack1}, 2'b00);
    set_req0(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    req0 = 1'b0;
    tick();
    chk("rmw_rd_ack", ack0, 1'b1);
    chk("rmw_old_value", rdata0, 32'hA000_0020);
    tick();

    // Reset asserted in RESP drops the ack
    set_req0(1'b1, 1'b1, 32'h30, 32'h55AA);
    tick();
    req0 = 1'b0;
    tick();
    chk("rresp_ack", ack0, 1'b1);
    reset = 1'b1;
    tick();
    chk("rresp_ack_clr", {ack0, dbg_state}, 3'b000);
    chk("rresp_rdata_clr", rdata0, 32'h0);
    reset = 1'b0;

    // Idle: nothing active for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_%0d", i),
          {mem_read_en, mem_write_en, gnt0, gnt1, ack0, ack1, mem_address},
          {6'b000000, 32'h0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
